riscv_wb_stage: RTL and testbench

Write-back stage of the kana-riscv core. It accepts completed instructions from the execute stage and selects the write-back source: ALU result, PC+4, CSR read data, or load data. For loads it waits for the data-memory response, then extracts and sign/zero-extends the data. It drives the register-file write port that feeds the operand-select muxes on the read side.

---
 rtl/riscv_constants.sv | 25 ++
 rtl/riscv_load_ext.sv | 29 ++
 rtl/riscv_wb_stage.sv | 152 +++++++++++++++
 tb/tb_riscv_wb_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_constants.sv
// Shared encodings for the kana-riscv write-back path: write-back source select,
// load funct3 codes and the write-back stage FSM states.
package riscv_constants;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2,
      WB_CSR = 2'd3
   } wb_sel_e;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } load_fn_e;

   typedef enum logic [0:0] {
      StIdle    = 1'b0,
      StWaitMem = 1'b1
   } wb_state_e;

endpackage

// File: rtl/riscv_load_ext.sv
// Load data extractor: picks the addressed byte/half from an aligned little-endian
// word and sign- or zero-extends it according to the load funct3.
module riscv_load_ext
   import riscv_constants::*;
#(
   parameter int unsigned WORD_LENGTH = 32
) (
   input  logic [2:0]             load_fn,
   input  logic [1:0]             offset,
   input  logic [WORD_LENGTH-1:0] rdata,
   output logic [WORD_LENGTH-1:0] ext
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[8*offset +: 8];
      half_sel = rdata[16*offset[1] +: 16];
      case (load_fn)
         LB:      ext = {{(WORD_LENGTH-8){byte_sel[7]}}, byte_sel};
         LH:      ext = {{(WORD_LENGTH-16){half_sel[15]}}, half_sel};
         LBU:     ext = {{(WORD_LENGTH-8){1'b0}}, byte_sel};
         LHU:     ext = {{(WORD_LENGTH-16){1'b0}}, half_sel};
         default: ext = rdata;
      endcase
   end

endmodule

// File: rtl/riscv_wb_stage.sv
// Write-back stage: selects ALU/PC+4/CSR/load data and drives the register-file write port.
// Optional early-forward port enabled with `RISCV_WB_BYPASS_EN.
module riscv_wb_stage
   import riscv_constants::*;
#(
   parameter int unsigned WORD_LENGTH    = 32,
   parameter int unsigned REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [1:0]                wb_sel,
   input  logic [2:0]                load_fn,
   input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
   input  logic                      rd_wen,
   input  logic [WORD_LENGTH-1:0]    alu_out,
   input  logic [WORD_LENGTH-1:0]    pc,
   input  logic [WORD_LENGTH-1:0]    csr_rdata,
   input  logic                      mem_rvalid,
   input  logic [WORD_LENGTH-1:0]    mem_rdata,
   output logic                      rf_we,
   output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
   output logic [WORD_LENGTH-1:0]    rf_wdata,
   output logic                      load_fault,
   output logic                      fwd_valid,
   output logic [REG_ADDR_WIDTH-1:0] fwd_addr,
   output logic [WORD_LENGTH-1:0]    fwd_data
);

   wb_state_e                 state_q, state_d;
   logic [2:0]                ld_fn_q, ld_fn_d;
   logic [1:0]                ld_off_q, ld_off_d;
   logic [REG_ADDR_WIDTH-1:0] ld_rd_q, ld_rd_d;
   logic                      ld_wen_q, ld_wen_d;
   logic                      rf_we_q, rf_we_d;
   logic [REG_ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
   logic [WORD_LENGTH-1:0]    rf_wdata_q, rf_wdata_d;
   logic                      load_fault_q, load_fault_d;
   logic [WORD_LENGTH-1:0]    ld_ext;
   logic                      ld_illegal;

   riscv_load_ext #(
      .WORD_LENGTH(WORD_LENGTH)
   ) u_load_ext (
      .load_fn(ld_fn_q),
      .offset (ld_off_q),
      .rdata  (mem_rdata),
      .ext    (ld_ext)
   );

   always_comb begin
      case (load_fn)
         LB, LBU: ld_illegal = 1'b0;
         LH, LHU: ld_illegal = alu_out[0];
         LW:      ld_illegal = alu_out[1:0] != 2'b00;
         default: ld_illegal = 1'b1;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      ld_fn_d      = ld_fn_q;
      ld_off_d     = ld_off_q;
      ld_rd_d      = ld_rd_q;
      ld_wen_d     = ld_wen_q;
      rf_we_d      = 1'b0;
      rf_waddr_d   = '0;
      rf_wdata_d   = '0;
      load_fault_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               if (wb_sel == WB_MEM) begin
                  if (ld_illegal) begin
                     load_fault_d = 1'b1;
                  end else begin
                     ld_fn_d  = load_fn;
                     ld_off_d = alu_out[1:0];
                     ld_rd_d  = rd_addr;
                     ld_wen_d = rd_wen;
                     state_d  = StWaitMem;
                  end
               end else begin
                  // x0 is hardwired to zero, so writes to it are never issued
                  rf_we_d = rd_wen && (rd_addr != '0);
                  if (rf_we_d) begin
                     rf_waddr_d = rd_addr;
                     case (wb_sel)
                        WB_PC4:  rf_wdata_d = pc + WORD_LENGTH'(4);
                        WB_CSR:  rf_wdata_d = csr_rdata;
                        default: rf_wdata_d = alu_out;
                     endcase
                  end
               end
            end
         end
         StWaitMem: begin
            if (mem_rvalid) begin
               rf_we_d = ld_wen_q && (ld_rd_q != '0);
               if (rf_we_d) begin
                  rf_waddr_d = ld_rd_q;
                  rf_wdata_d = ld_ext;
               end
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         ld_fn_q      <= 3'b000;
         ld_off_q     <= 2'b00;
         ld_rd_q      <= '0;
         ld_wen_q     <= 1'b0;
         rf_we_q      <= 1'b0;
         rf_waddr_q   <= '0;
         rf_wdata_q   <= '0;
         load_fault_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ld_fn_q      <= ld_fn_d;
         ld_off_q     <= ld_off_d;
         ld_rd_q      <= ld_rd_d;
         ld_wen_q     <= ld_wen_d;
         rf_we_q      <= rf_we_d;
         rf_waddr_q   <= rf_waddr_d;
         rf_wdata_q   <= rf_wdata_d;
         load_fault_q <= load_fault_d;
      end
   end

   assign in_ready   = (state_q == StIdle);
   assign rf_we      = rf_we_q;
   assign rf_waddr   = rf_waddr_q;
   assign rf_wdata   = rf_wdata_q;
   assign load_fault = load_fault_q;

`ifdef RISCV_WB_BYPASS_EN
   assign fwd_valid = rf_we_d;
   assign fwd_addr  = rf_waddr_d;
   assign fwd_data  = rf_wdata_d;
`else
   assign fwd_valid = 1'b0;
   assign fwd_addr  = '0;
   assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_riscv_wb_stage.sv
// Directed, table-driven bench for riscv_wb_stage; forward-port checks under RISCV_WB_BYPASS_EN.
module tb_riscv_wb_stage;
   import riscv_constants::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  wb_sel;
   logic [2:0]  load_fn;
   logic [4:0]  rd_addr;
   logic        rd_wen;
   logic [31:0] alu_out, pc, csr_rdata, mem_rdata;
   logic        mem_rvalid;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        load_fault;
   logic        fwd_valid;
   logic [4:0]  fwd_addr;
   logic [31:0] fwd_data;

   int n_checks = 0;
   int n_fail   = 0;

   riscv_wb_stage #(
      .WORD_LENGTH   (32),
      .REG_ADDR_WIDTH(5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .wb_sel    (wb_sel),
      .load_fn   (load_fn),
      .rd_addr   (rd_addr),
      .rd_wen    (rd_wen),
      .alu_out   (alu_out),
      .pc        (pc),
      .csr_rdata (csr_rdata),
      .mem_rvalid(mem_rvalid),
      .mem_rdata (mem_rdata),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .load_fault(load_fault),
      .fwd_valid (fwd_valid),
      .fwd_addr  (fwd_addr),
      .fwd_data  (fwd_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  sel;
      logic [2:0]  fn;
      logic [4:0]  rd;
      logic        wen;
      logic [31:0] alu;
      logic [31:0] pcv;
      logic [31:0] csr;
      logic [31:0] rdata;
      int          delay;
      logic        exp_we;
      logic [31:0] exp_data;
      logic        exp_fault;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] sel, input logic [2:0] fn, input logic [4:0] rd,
                        input logic wen, input logic [31:0] alu, input logic [31:0] pcv,
                        input logic [31:0] csr);
      in_valid  = 1'b1;
      wb_sel    = sel;
      load_fn   = fn;
      rd_addr   = rd;
      rd_wen    = wen;
      alu_out   = alu;
      pc        = pcv;
      csr_rdata = csr;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic is_load;
      is_load = (v.sel == WB_MEM) && !v.exp_fault;
      drive(v.sel, v.fn, v.rd, v.wen, v.alu, v.pcv, v.csr);
`ifdef RISCV_WB_BYPASS_EN
      if (!is_load) begin
         #1;
         chk($sformatf("v%0d_fwd_valid", idx), {31'b0, fwd_valid}, {31'b0, v.exp_we});
         if (v.exp_we) chk($sformatf("v%0d_fwd_data", idx), fwd_data, v.exp_data);
      end
`endif
      step();
      in_valid = 1'b0;
      if (is_load) begin
         chk($sformatf("v%0d_wait_ready", idx), {31'b0, in_ready}, 32'd0);
         for (int i = 0; i < v.delay; i++) begin
            step();
            chk($sformatf("v%0d_wait_we", idx), {31'b0, rf_we}, 32'd0);
         end
         mem_rdata  = v.rdata;
         mem_rvalid = 1'b1;
`ifdef RISCV_WB_BYPASS_EN
         #1;
         chk($sformatf("v%0d_fwd_valid", idx), {31'b0, fwd_valid}, {31'b0, v.exp_we});
         if (v.exp_we) begin
            chk($sformatf("v%0d_fwd_addr", idx), {27'b0, fwd_addr}, {27'b0, v.rd});
            chk($sformatf("v%0d_fwd_data", idx), fwd_data, v.exp_data);
         end
`endif
         step();
         mem_rvalid = 1'b0;
      end
      chk($sformatf("v%0d_we", idx), {31'b0, rf_we}, {31'b0, v.exp_we});
      if (v.exp_we) begin
         chk($sformatf("v%0d_waddr", idx), {27'b0, rf_waddr}, {27'b0, v.rd});
         chk($sformatf("v%0d_wdata", idx), rf_wdata, v.exp_data);
      end
      chk($sformatf("v%0d_fault", idx), {31'b0, load_fault}, {31'b0, v.exp_fault});
      chk($sformatf("v%0d_ready", idx), {31'b0, in_ready}, 32'd1);
      step();
      chk($sformatf("v%0d_we_drop", idx), {31'b0, rf_we}, 32'd0);
      chk($sformatf("v%0d_fault_drop", idx), {31'b0, load_fault}, 32'd0);
   endtask

   initial begin
      //            sel     fn      rd  wen alu           pc            csr           rdata        dly we data          fault
      vecs[0]  = '{WB_ALU, 3'b000, 5'd1, 1, 32'h12345678, 32'h0,        32'h0,        32'h0,        0, 1, 32'h12345678, 0};
      vecs[1]  = '{WB_PC4, 3'b000, 5'd2, 1, 32'h0,        32'hFFFFFFFC, 32'h0,        32'h0,        0, 1, 32'h00000000, 0};
      vecs[2]  = '{WB_CSR, 3'b000, 5'd0, 1, 32'h0,        32'h0,        32'hDEADBEEF, 32'h0,        0, 0, 32'h0,        0};
      vecs[3]  = '{WB_MEM, LB,     5'd5, 1, 32'h00001003, 32'h0,        32'h0,        32'h80FF00AA, 0, 1, 32'hFFFFFF80, 0};
      vecs[4]  = '{WB_MEM, LBU,    5'd5, 1, 32'h00001003, 32'h0,        32'h0,        32'h80FF00AA, 1, 1, 32'h00000080, 0};
      vecs[5]  = '{WB_MEM, LH,     5'd6, 1, 32'h00002002, 32'h0,        32'h0,        32'h80017FFF, 2, 1, 32'hFFFF8001, 0};
      vecs[6]  = '{WB_MEM, LW,     5'd6, 1, 32'h00002002, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0,        1};
      vecs[7]  = '{WB_MEM, LW,     5'd3, 1, 32'h00002000, 32'h0,        32'h0,        32'hCAFEF00D, 4, 1, 32'hCAFEF00D, 0};
      vecs[8]  = '{WB_MEM, LHU,    5'd9, 1, 32'h00000000, 32'h0,        32'h0,        32'h80017FFF, 0, 1, 32'h00007FFF, 0};
      vecs[9]  = '{WB_MEM, 3'b011, 5'd9, 1, 32'h00000000, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0,        1};
      vecs[10] = '{WB_MEM, LB,     5'd4, 1, 32'h00000001, 32'h0,        32'h0,        32'h80FF00AA, 0, 1, 32'h00000000, 0};
      vecs[11] = '{WB_CSR, 3'b000, 5'd7, 0, 32'h0,        32'h0,        32'h11112222, 32'h0,        0, 0, 32'h0,        0};
      vecs[12] = '{WB_MEM, LH,     5'd4, 1, 32'h00000001, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0,        1};
      vecs[13] = '{WB_MEM, LB,     5'd10, 1, 32'h00000002, 32'h0,       32'h0,        32'h80FF00AA, 3, 1, 32'hFFFFFFFF, 0};

      rst        = 1'b1;
      in_valid   = 1'b0;
      wb_sel     = WB_ALU;
      load_fn    = 3'b000;
      rd_addr    = '0;
      rd_wen     = 1'b0;
      alu_out    = '0;
      pc         = '0;
      csr_rdata  = '0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      step();
      step();
      rst = 1'b0;
      step();

      chk("rst_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_we", {31'b0, rf_we}, 32'd0);
      chk("rst_waddr", {27'b0, rf_waddr}, 32'd0);
      chk("rst_wdata", rf_wdata, 32'd0);
      chk("rst_fault", {31'b0, load_fault}, 32'd0);
      chk("rst_fwd_valid", {31'b0, fwd_valid}, 32'd0);
      chk("rst_fwd_data", fwd_data, 32'd0);

      for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

      // Back-to-back ALU then PC+4: writes in consecutive cycles
      drive(WB_ALU, 3'b000, 5'd1, 1'b1, 32'h12345678, 32'h0, 32'h0);
      step();
      drive(WB_PC4, 3'b000, 5'd2, 1'b1, 32'h0, 32'hFFFFFFFC, 32'h0);
      chk("b2b_we0", {31'b0, rf_we}, 32'd1);
      chk("b2b_data0", rf_wdata, 32'h12345678);
      step();
      in_valid = 1'b0;
      chk("b2b_we1", {31'b0, rf_we}, 32'd1);
      chk("b2b_addr1", {27'b0, rf_waddr}, 32'd2);
      chk("b2b_data1", rf_wdata, 32'h00000000);
      step();
      chk("b2b_we_drop", {31'b0, rf_we}, 32'd0);

      // Load followed immediately by an ALU op accepted at edge M+1
      drive(WB_MEM, LW, 5'd11, 1'b1, 32'h00000100, 32'h0, 32'h0);
      step();
      in_valid   = 1'b0;
      mem_rdata  = 32'hA5A5_0001;
      mem_rvalid = 1'b1;
      step();
      mem_rvalid = 1'b0;
      drive(WB_ALU, 3'b000, 5'd12, 1'b1, 32'h0BAD_F00D, 32'h0, 32'h0);
      chk("ld_alu_we0", {31'b0, rf_we}, 32'd1);
      chk("ld_alu_data0", rf_wdata, 32'hA5A50001);
      step();
      in_valid = 1'b0;
      chk("ld_alu_we1", {31'b0, rf_we}, 32'd1);
      chk("ld_alu_addr1", {27'b0, rf_waddr}, 32'd12);
      chk("ld_alu_data1", rf_wdata, 32'h0BADF00D);
      step();

      // Reset while a load is pending: load dropped, stray rvalid ignored
      drive(WB_MEM, LW, 5'd8, 1'b1, 32'h00000040, 32'h0, 32'h0);
      step();
      in_valid = 1'b0;
      chk("rmid_wait_ready", {31'b0, in_ready}, 32'd0);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      chk("rmid_ready", {31'b0, in_ready}, 32'd1);
      mem_rdata  = 32'h1234_5678;
      mem_rvalid = 1'b1;
`ifdef RISCV_WB_BYPASS_EN
      #1;
      chk("rmid_fwd_valid", {31'b0, fwd_valid}, 32'd0);
`endif
      step();
      mem_rvalid = 1'b0;
      chk("rmid_we0", {31'b0, rf_we}, 32'd0);
      chk("rmid_ready2", {31'b0, in_ready}, 32'd1);
      step();
      chk("rmid_we1", {31'b0, rf_we}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
